// File: rtl/axi_ram_arbiter_if.sv
// axi_ram_arbiter_if: single-beat AXI4 bus between the arbiter (master) and the shared RAM (slave)
interface axi_ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 12
) ();
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  logic [ID_WIDTH-1:0]   awid, arid, bid, rid;
  logic [ADDR_WIDTH-1:0] awaddr, araddr;
  logic [7:0]            awlen, arlen;
  logic [2:0]            awsize, arsize;
  logic [1:0]            awburst, arburst, bresp, rresp;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic                  arvalid, arready, rvalid, rready, rlast;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_ram_arbiter.sv
// axi_ram_arbiter: round-robin arbiter turning single-word requests into single-beat AXI4 transactions.
// Define ARB_ERR_CHECK_EN to add the sticky err output checking response id/resp/last.
module axi_ram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  axi_ram_arbiter_if.master             m_axi
`ifdef ARB_ERR_CHECK_EN
  , output logic                        err
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d, rr_q, rr_d, pick;
  logic                  found;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  arv_q, arv_d, awv_q, awv_d, wv_q, wv_d, rready_q, rready_d, bready_q, bready_d;
  logic [NUM_REQ-1:0]    resp_q, resp_d, onehot;
  // Scan offsets high to low so the smallest offset past rr_q wins
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        pick = IW'((int'(rr_q) + k) % NUM_REQ);
        found = 1'b1;
      end
  end
  assign onehot = NUM_REQ'(1) << idx_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    rr_d = rr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    arv_d = arv_q;
    awv_d = awv_q;
    wv_d = wv_q;
    rready_d = rready_q;
    bready_d = bready_q;
    resp_d = '0;
    case (state_q)
      IDLE: if (found) begin
        idx_d = pick;
        rr_d = pick;
        addr_d = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_d = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
        wstrb_d = req_wstrb[pick*STRB_WIDTH +: STRB_WIDTH];
        state_d = req_we[pick] ? WR_ADDR : RD_ADDR;
        arv_d = !req_we[pick];
        awv_d = req_we[pick];
        wv_d = req_we[pick];
      end
      RD_ADDR: if (m_axi.arready) begin
        arv_d = 1'b0;
        rready_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: if (m_axi.rvalid) begin
        rdata_d = m_axi.rdata;
        resp_d = onehot;
        rready_d = 1'b0;
        state_d = IDLE;
      end
      WR_ADDR: begin
        awv_d = awv_q && !m_axi.awready;
        wv_d = wv_q && !m_axi.wready;
        if (!awv_d && !wv_d) begin
          bready_d = 1'b1;
          state_d = WR_RESP;
        end
      end
      WR_RESP: if (m_axi.bvalid) begin
        resp_d = onehot;
        bready_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= IW'(NUM_REQ - 1);
      idx_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      {arv_q, awv_q, wv_q, rready_q, bready_q} <= '0;
      resp_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      idx_q <= idx_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      {arv_q, awv_q, wv_q, rready_q, bready_q} <= {arv_d, awv_d, wv_d, rready_d, bready_d};
      resp_q <= resp_d;
    end
  end
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
  assign m_axi.awid = ID_WIDTH'(idx_q);
  assign m_axi.arid = ID_WIDTH'(idx_q);
  assign m_axi.awaddr = addr_q;
  assign m_axi.araddr = addr_q;
  assign m_axi.awlen = 8'd0;
  assign m_axi.arlen = 8'd0;
  assign m_axi.awsize = 3'($clog2(STRB_WIDTH));
  assign m_axi.arsize = 3'($clog2(STRB_WIDTH));
  assign m_axi.awburst = 2'b01;
  assign m_axi.arburst = 2'b01;
  assign m_axi.awvalid = awv_q;
  assign m_axi.wdata = wdata_q;
  assign m_axi.wstrb = wstrb_q;
  assign m_axi.wlast = 1'b1;
  assign m_axi.wvalid = wv_q;
  assign m_axi.bready = bready_q;
  assign m_axi.arvalid = arv_q;
  assign m_axi.rready = rready_q;
`ifdef ARB_ERR_CHECK_EN
  logic err_q, err_d, r_bad, b_bad;
  assign r_bad = m_axi.rid != ID_WIDTH'(idx_q) || m_axi.rresp != 2'b00 || !m_axi.rlast;
  assign b_bad = m_axi.bid != ID_WIDTH'(idx_q) || m_axi.bresp != 2'b00;
  assign err_d = err_q | (state_q == RD_DATA && m_axi.rvalid && r_bad) | (state_q == WR_RESP && m_axi.bvalid && b_bad);
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
  assign err = err_q;
`else
  logic unused_resp;
  assign unused_resp = ^{m_axi.rid, m_axi.rresp, m_axi.rlast, m_axi.bid, m_axi.bresp};
`endif
endmodule

// File: tb/tb_axi_ram_arbiter.sv
// tb_axi_ram_arbiter: directed bench for axi_ram_arbiter with a small AXI RAM slave model
module tb_axi_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_we, resp_valid;
  logic [31:0] req_addr, resp_rdata;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  int          checks = 0, passes = 0;
  int          aw_delay, r_delay, aw_cnt, r_cnt;
  logic [1:0]  rresp_inj;
  logic        r_pend, aw_got, w_got;
  logic [15:0] wa;
  logic [31:0] wd;
  logic [3:0]  ws;
  logic [31:0] mem [0:63];
`ifdef ARB_ERR_CHECK_EN
  logic        err;
`endif
  axi_ram_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(12)) m ();
  axi_ram_arbiter #(.NUM_REQ(2), .DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .m_axi(m)
`ifdef ARB_ERR_CHECK_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  assign m.wready = 1'b1;
  assign m.arready = 1'b1;
  assign m.rlast = 1'b1;
  assign m.rresp = rresp_inj;
  assign m.bresp = 2'b00;
  always @(posedge clk) begin
    if (rst) begin
      m.awready <= 1'b0;
      m.rvalid <= 1'b0;
      m.bvalid <= 1'b0;
      m.rdata <= '0;
      m.rid <= '0;
      m.bid <= '0;
      r_pend <= 1'b0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      aw_cnt <= 0;
      r_cnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h11223344;
      mem[16] <= 32'hA0A0A0A0;
      mem[17] <= 32'hA4A4A4A4;
    end else begin
      if (m.awvalid && m.awready) begin
        m.awready <= 1'b0;
        aw_cnt <= 0;
        aw_got <= 1'b1;
        wa <= m.awaddr;
        m.bid <= m.awid;
      end else if (m.awvalid) begin
        if (aw_cnt == aw_delay) m.awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (m.wvalid && m.wready) begin
        w_got <= 1'b1;
        wd <= m.wdata;
        ws <= m.wstrb;
      end
      if (aw_got && w_got && !m.bvalid) begin
        for (int b = 0; b < 4; b++) if (ws[b]) mem[wa[7:2]][8*b +: 8] <= wd[8*b +: 8];
        m.bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      if (m.bvalid && m.bready) m.bvalid <= 1'b0;
      if (m.arvalid && m.arready) begin
        r_pend <= 1'b1;
        r_cnt <= 0;
        m.rdata <= mem[m.araddr[7:2]];
        m.rid <= m.arid;
      end else if (r_pend) begin
        if (r_cnt == r_delay) begin
          m.rvalid <= 1'b1;
          r_pend <= 1'b0;
        end else r_cnt <= r_cnt + 1;
      end
      if (m.rvalid && m.rready) m.rvalid <= 1'b0;
    end
  end

  task automatic do_req(input int r, input logic we, input logic [15:0] addr, input logic [31:0] wdat,
                        input logic [3:0] strb, output logic [1:0] got, output logic [31:0] rd,
                        output logic [11:0] gid, output logic [15:0] gaddr, output int awc, output int wc, output int bc);
    got = '0; rd = '0; gid = '1; gaddr = '1; awc = 0; wc = 0; bc = 0;
    req_we[r] = we;
    req_addr[r*16 +: 16] = addr;
    req_wdata[r*32 +: 32] = wdat;
    req_wstrb[r*4 +: 4] = strb;
    req_valid[r] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (m.arvalid) begin gid = m.arid; gaddr = m.araddr; end
      if (m.awvalid) begin gid = m.awid; gaddr = m.awaddr; awc++; end
      if (m.wvalid) wc++;
      if (m.bvalid && m.bready) bc++;
      if (resp_valid != 0) begin got = resp_valid; rd = resp_rdata; break; end
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (m.arvalid !== 1'b0) $display("FAIL rst_arvalid: got %b exp 0", m.arvalid); else passes++;
    checks++; if (m.awvalid !== 1'b0) $display("FAIL rst_awvalid: got %b exp 0", m.awvalid); else passes++;
    checks++; if (m.wvalid !== 1'b0) $display("FAIL rst_wvalid: got %b exp 0", m.wvalid); else passes++;
    checks++; if (m.rready !== 1'b0) $display("FAIL rst_rready: got %b exp 0", m.rready); else passes++;
    checks++; if (m.bready !== 1'b0) $display("FAIL rst_bready: got %b exp 0", m.bready); else passes++;
    checks++; if (resp_valid !== 2'b00) $display("FAIL rst_resp_valid: got %b exp 00", resp_valid); else passes++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata: got %h exp 0", resp_rdata); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_read();
    logic [1:0] got;
    logic [31:0] rd;
    bit seen;
    got = '0; rd = '0; seen = 0;
    req_we[0] = 1'b0;
    req_addr[15:0] = 16'h0010;
    req_valid[0] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (m.arvalid && !seen) begin
        seen = 1;
        checks++; if (m.arid !== 12'd0) $display("FAIL rd_arid: got %0d exp 0", m.arid); else passes++;
        checks++; if (m.araddr !== 16'h0010) $display("FAIL rd_araddr: got %h exp 0010", m.araddr); else passes++;
        checks++; if (m.arlen !== 8'd0) $display("FAIL rd_arlen: got %0d exp 0", m.arlen); else passes++;
        checks++; if (m.arsize !== 3'd2) $display("FAIL rd_arsize: got %0d exp 2", m.arsize); else passes++;
        checks++; if (m.arburst !== 2'b01) $display("FAIL rd_arburst: got %b exp 01", m.arburst); else passes++;
      end
      if (resp_valid != 0) begin got = resp_valid; rd = resp_rdata; break; end
    end
    req_valid[0] = 1'b0;
    checks++; if (!seen) $display("FAIL rd_ar_seen: got 0 exp 1"); else passes++;
    checks++; if (got !== 2'b01) $display("FAIL rd_resp_valid: got %b exp 01", got); else passes++;
    checks++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h exp deadbeef", rd); else passes++;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 2'b00) $display("FAIL rd_pulse_width: got %b exp 00", resp_valid); else passes++;
  endtask

  task automatic test_write_readback();
    logic [1:0] got;
    logic [31:0] rd;
    logic [11:0] gid;
    logic [15:0] ga;
    int awc, wc, bc;
    do_req(1, 1'b1, 16'h0020, 32'hCAFEF00D, 4'b0011, got, rd, gid, ga, awc, wc, bc);
    checks++; if (got !== 2'b10) $display("FAIL wr_resp_valid: got %b exp 10", got); else passes++;
    checks++; if (gid !== 12'd1) $display("FAIL wr_awid: got %0d exp 1", gid); else passes++;
    checks++; if (ga !== 16'h0020) $display("FAIL wr_awaddr: got %h exp 0020", ga); else passes++;
    checks++; if (bc !== 1) $display("FAIL wr_b_count: got %0d exp 1", bc); else passes++;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 2'b00) $display("FAIL wr_pulse_width: got %b exp 00", resp_valid); else passes++;
    do_req(1, 1'b0, 16'h0020, 32'h0, 4'h0, got, rd, gid, ga, awc, wc, bc);
    checks++; if (got !== 2'b10) $display("FAIL wrb_resp_valid: got %b exp 10", got); else passes++;
    checks++; if (rd !== 32'h1122F00D) $display("FAIL wrb_rdata: got %h exp 1122f00d", rd); else passes++;
    @(posedge clk); #1;
    checks++; if (resp_valid !== 2'b00) $display("FAIL wrb_pulse_width: got %b exp 00", resp_valid); else passes++;
  endtask

  task automatic test_round_robin();
    logic [1:0] got, exp_v;
    logic [31:0] rd;
    logic [11:0] gid;
    logic [15:0] ga;
    req_we = 2'b00;
    req_addr = {16'h0044, 16'h0040};
    req_valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      got = '0; rd = '0; gid = '1; ga = '1;
      exp_v = (t % 2 == 0) ? 2'b01 : 2'b10;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (m.arvalid) begin gid = m.arid; ga = m.araddr; end
        if (resp_valid != 0) begin got = resp_valid; rd = resp_rdata; break; end
      end
      if (t == 5) req_valid = 2'b00;
      checks++; if (got !== exp_v) $display("FAIL rr_grant%0d: got %b exp %b", t, got, exp_v); else passes++;
      checks++; if (gid !== 12'(t % 2)) $display("FAIL rr_arid%0d: got %0d exp %0d", t, gid, t % 2); else passes++;
      checks++; if (ga !== ((t % 2 == 0) ? 16'h0040 : 16'h0044)) $display("FAIL rr_araddr%0d: got %h", t, ga); else passes++;
      checks++; if (rd !== ((t % 2 == 0) ? 32'hA0A0A0A0 : 32'hA4A4A4A4)) $display("FAIL rr_rdata%0d: got %h", t, rd); else passes++;
    end
  endtask

  task automatic test_aw_delay();
    logic [1:0] got;
    logic [31:0] rd;
    logic [11:0] gid;
    logic [15:0] ga;
    int awc, wc, bc;
    aw_delay = 3;
    do_req(0, 1'b1, 16'h0030, 32'h55AA55AA, 4'hF, got, rd, gid, ga, awc, wc, bc);
    aw_delay = 0;
    checks++; if (got !== 2'b01) $display("FAIL awd_resp_valid: got %b exp 01", got); else passes++;
    checks++; if (awc !== 5) $display("FAIL awd_awvalid_cycles: got %0d exp 5", awc); else passes++;
    checks++; if (wc !== 1) $display("FAIL awd_wvalid_cycles: got %0d exp 1", wc); else passes++;
    checks++; if (bc !== 1) $display("FAIL awd_b_count: got %0d exp 1", bc); else passes++;
    do_req(0, 1'b0, 16'h0030, 32'h0, 4'h0, got, rd, gid, ga, awc, wc, bc);
    checks++; if (rd !== 32'h55AA55AA) $display("FAIL awd_readback: got %h exp 55aa55aa", rd); else passes++;
  endtask

  task automatic test_rst_mid();
    bit reached, stray;
    logic [1:0] got;
    logic [31:0] rd;
    reached = 0; stray = 0;
    r_delay = 10;
    req_we = 2'b00;
    req_addr[15:0] = 16'h0010;
    req_valid = 2'b01;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (m.rready) begin reached = 1; break; end
    end
    checks++; if (!reached) $display("FAIL rstm_rd_data_reached: got 0 exp 1"); else passes++;
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    checks++; if ({m.arvalid, m.awvalid, m.wvalid, m.rready, m.bready} !== 5'b0)
      $display("FAIL rstm_valids: got %b exp 00000", {m.arvalid, m.awvalid, m.wvalid, m.rready, m.bready}); else passes++;
    checks++; if (resp_valid !== 2'b00) $display("FAIL rstm_resp_valid: got %b exp 00", resp_valid); else passes++;
    rst = 1'b0;
    r_delay = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (resp_valid != 0 || m.arvalid) stray = 1;
    end
    checks++; if (stray) $display("FAIL rstm_abandoned: got activity exp none"); else passes++;
    req_addr = {16'h0044, 16'h0040};
    req_valid = 2'b11;
    for (int t = 0; t < 2; t++) begin
      got = '0; rd = '0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (resp_valid != 0) begin got = resp_valid; rd = resp_rdata; break; end
      end
      req_valid[t] = 1'b0;
      checks++; if (got !== (t == 0 ? 2'b01 : 2'b10)) $display("FAIL rstm_grant%0d: got %b", t, got); else passes++;
      checks++; if (rd !== (t == 0 ? 32'hA0A0A0A0 : 32'hA4A4A4A4)) $display("FAIL rstm_rdata%0d: got %h", t, rd); else passes++;
    end
  endtask

`ifdef ARB_ERR_CHECK_EN
  task automatic test_err();
    logic [1:0] got;
    logic [31:0] rd;
    logic [11:0] gid;
    logic [15:0] ga;
    int awc, wc, bc;
    checks++; if (err !== 1'b0) $display("FAIL err_initial: got %b exp 0", err); else passes++;
    rresp_inj = 2'b10;
    do_req(0, 1'b0, 16'h0010, 32'h0, 4'h0, got, rd, gid, ga, awc, wc, bc);
    rresp_inj = 2'b00;
    checks++; if (got !== 2'b01) $display("FAIL err_resp_delivered: got %b exp 01", got); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL err_set: got %b exp 1", err); else passes++;
    do_req(1, 1'b0, 16'h0044, 32'h0, 4'h0, got, rd, gid, ga, awc, wc, bc);
    checks++; if (rd !== 32'hA4A4A4A4) $display("FAIL err_clean_rdata: got %h exp a4a4a4a4", rd); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b exp 1", err); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (err !== 1'b0) $display("FAIL err_cleared: got %b exp 0", err); else passes++;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, exp finish before 500000");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    aw_delay = 0; r_delay = 0; rresp_inj = 2'b00;
    test_reset();
    test_read();
    test_write_readback();
    test_round_robin();
    test_aw_delay();
    test_rst_mid();
`ifdef ARB_ERR_CHECK_EN
    test_err();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
